// File: rtl/rom_burst_arbiter_pkg.sv
// rom_burst_arbiter_pkg: shared widths, FSM state encoding and requester ids
package rom_burst_arbiter_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
  typedef enum logic {IDLE, BURST} state_t;
endpackage

// File: rtl/rom_burst_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant; on a tie the requester that did not win last time wins
module rr_arb2
  import rom_burst_arbiter_pkg::*;
(
  input  logic v0,
  input  logic v1,
  input  logic last_grant,
  output logic gnt,
  output logic gnt_id
);
  assign gnt    = v0 | v1;
  assign gnt_id = (v0 & v1) ? ~last_grant : (v1 ? REQ1 : REQ0);
endmodule

// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter: round-robin burst reader streaming ROM words onto a valid/ready port
module rom_burst_arbiter
  import rom_burst_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [ADDR_W-1:0] req0_len,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [ADDR_W-1:0] req1_len,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_id,
  output logic              out_last,
  output logic              busy
);
  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_n, beat_cnt, cnt_n, len_q, len_n;
  logic              id_n, last_grant, lg_n, gnt, gnt_id;

  rr_arb2 u_arb (
    .v0        (req0_valid),
    .v1        (req1_valid),
    .last_grant(last_grant),
    .gnt       (gnt),
    .gnt_id    (gnt_id)
  );

  assign req0_ready = (state == IDLE) && gnt && (gnt_id == REQ0);
  assign req1_ready = (state == IDLE) && gnt && (gnt_id == REQ1);
  assign out_valid  = (state == BURST);
  assign busy       = out_valid;
  assign out_data   = out_valid ? rom_data : '0;
  assign out_last   = out_valid && (beat_cnt == len_q);

  // next-state: load a granted burst in IDLE, step the address on each accepted beat in BURST
  always_comb begin
    state_n = state;
    addr_n  = rom_addr;
    cnt_n   = beat_cnt;
    len_n   = len_q;
    id_n    = out_id;
    lg_n    = last_grant;
    if (state == IDLE && gnt) begin
      state_n = BURST;
      addr_n  = gnt_id ? req1_addr : req0_addr;
      len_n   = gnt_id ? req1_len : req0_len;
      cnt_n   = '0;
      id_n    = gnt_id;
      lg_n    = gnt_id;
    end else if (state == BURST && out_ready) begin
      state_n = out_last ? IDLE : BURST;
      addr_n  = out_last ? rom_addr : rom_addr + 1'b1;
      cnt_n   = out_last ? beat_cnt : beat_cnt + 1'b1;
    end
  end

  // state and burst registers; last_grant resets to REQ1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rom_addr   <= '0;
      beat_cnt   <= '0;
      len_q      <= '0;
      out_id     <= REQ0;
      last_grant <= REQ1;
    end else begin
      state      <= state_n;
      rom_addr   <= addr_n;
      beat_cnt   <= cnt_n;
      len_q      <= len_n;
      out_id     <= id_n;
      last_grant <= lg_n;
    end
  end
endmodule
